hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage RV32 core. It drives stall and flush to fetch, decoder_stage and execute. It detects load-use dependencies against decoder_stage source registers, holds the pipe while data memory is busy, and sequences the two-cycle flush after a taken branch/jump or a decode exception. A watchdog flags a stuck memory access.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 53 +++++
 rtl/hazard_ctrl_watchdog.sv | 42 ++++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared core definitions (datapath field widths) plus the
// hazard controller state encoding.
package hazard_ctrl_pkg;

  localparam int unsigned ALU_OP_WIDTH    = 4;
  localparam int unsigned OPCODE_WIDTH    = 7;
  localparam int unsigned EXCEPTION_WIDTH = 4;

  localparam int unsigned HC_STATE_WIDTH  = 2;

  typedef enum logic [HC_STATE_WIDTH-1:0] {
    HC_RUN      = 2'd0,
    HC_MEM_WAIT = 2'd1,
    HC_FLUSH1   = 2'd2,
    HC_FLUSH2   = 2'd3
  } hc_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline status inputs and stall/flush outputs of the
// hazard controller. Perf counter signals exist only with HAZARD_PERF_CNT_EN.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH = 5
);
  logic              hc_i_ds_ce;
  logic [AWIDTH-1:0] hc_i_ds_rs1;
  logic [AWIDTH-1:0] hc_i_ds_rs2;
  logic              hc_i_ds_use_rs1;
  logic              hc_i_ds_use_rs2;
  logic              hc_i_ex_ce;
  logic              hc_i_ex_load;
  logic [AWIDTH-1:0] hc_i_ex_rd;
  logic              hc_i_br_taken;
  logic              hc_i_trap;
  logic              hc_i_mem_busy;

  logic                      hc_o_if_stall;
  logic                      hc_o_ds_stall;
  logic                      hc_o_ds_flush;
  logic                      hc_o_ex_flush;
  logic [HC_STATE_WIDTH-1:0] hc_o_state;
  logic                      hc_o_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]               hc_o_stall_cnt;
  logic [31:0]               hc_o_flush_cnt;
`endif

  modport master (
    output hc_i_ds_ce, hc_i_ds_rs1, hc_i_ds_rs2, hc_i_ds_use_rs1,
           hc_i_ds_use_rs2, hc_i_ex_ce, hc_i_ex_load, hc_i_ex_rd,
           hc_i_br_taken, hc_i_trap, hc_i_mem_busy,
    input  hc_o_if_stall, hc_o_ds_stall, hc_o_ds_flush, hc_o_ex_flush,
`ifdef HAZARD_PERF_CNT_EN
           hc_o_stall_cnt, hc_o_flush_cnt,
`endif
           hc_o_state, hc_o_timeout
  );

  modport slave (
    input  hc_i_ds_ce, hc_i_ds_rs1, hc_i_ds_rs2, hc_i_ds_use_rs1,
           hc_i_ds_use_rs2, hc_i_ex_ce, hc_i_ex_load, hc_i_ex_rd,
           hc_i_br_taken, hc_i_trap, hc_i_mem_busy,
    output hc_o_if_stall, hc_o_ds_stall, hc_o_ds_flush, hc_o_ex_flush,
`ifdef HAZARD_PERF_CNT_EN
           hc_o_stall_cnt, hc_o_flush_cnt,
`endif
           hc_o_state, hc_o_timeout
  );

endinterface

// File: rtl/hazard_ctrl_watchdog.sv
// hc_watchdog: saturating cycle counter with synchronous clear and enable,
// plus a sticky flag that sets once the count reaches TIMEOUT.
module hc_watchdog #(
  parameter int unsigned CWIDTH  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic flag
);
  localparam logic [CWIDTH-1:0] LIMIT = CWIDTH'(TIMEOUT);

  logic [CWIDTH-1:0] cnt_q;
  logic [CWIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise count enabled cycles up to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register and sticky flag; the flag is set on the same edge the
  // count reaches the limit, so it is visible the cycle after.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      flag  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (en && (cnt_d >= LIMIT)) begin
        flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use detection, memory-wait hold and two-cycle flush
// sequencing for the five-stage pipe. Optional perf counters are enabled by
// defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned AWIDTH  = 5,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CWIDTH  = 8
) (
  input  logic          hc_clk,
  input  logic          hc_rst,
  hazard_ctrl_if.slave  hc
);
  import hazard_ctrl_pkg::*;

  hc_state_t state_q, state_d;
  logic      pend_q, pend_d;
  logic      lu, trap;
  logic      if_stall, ds_stall, ds_flush, ex_flush;
  logic      tmo;

  assign trap = hc.hc_i_trap & hc.hc_i_ds_ce;
  assign lu   = hc.hc_i_ds_ce & hc.hc_i_ex_ce & hc.hc_i_ex_load &
                (hc.hc_i_ex_rd != AWIDTH'(0)) &
                ((hc.hc_i_ds_use_rs1 & (hc.hc_i_ds_rs1 == hc.hc_i_ex_rd)) |
                 (hc.hc_i_ds_use_rs2 & (hc.hc_i_ds_rs2 == hc.hc_i_ex_rd)));

  // Next state, pending-branch latch and hazard outputs; priority is
  // mem_busy > br_taken > trap > load-use.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    if_stall = 1'b0;
    ds_stall = 1'b0;
    ds_flush = 1'b0;
    ex_flush = 1'b0;
    unique case (state_q)
      HC_RUN: begin
        if (hc.hc_i_mem_busy) begin
          if_stall = 1'b1;
          ds_stall = 1'b1;
          pend_d   = hc.hc_i_br_taken;
          state_d  = HC_MEM_WAIT;
        end else if (hc.hc_i_br_taken || trap) begin
          ds_flush = 1'b1;
          ex_flush = 1'b1;
          state_d  = HC_FLUSH1;
        end else if (lu) begin
          if_stall = 1'b1;
          ds_stall = 1'b1;
          ex_flush = 1'b1;
        end
      end
      HC_MEM_WAIT: begin
        if_stall = 1'b1;
        ds_stall = 1'b1;
        if (hc.hc_i_br_taken) begin
          pend_d = 1'b1;
        end
        if (!hc.hc_i_mem_busy) begin
          pend_d  = 1'b0;
          state_d = (pend_q || hc.hc_i_br_taken) ? HC_FLUSH1 : HC_RUN;
        end
      end
      // A memory stall during either flush cycle replays the full flush.
      HC_FLUSH1: begin
        if (hc.hc_i_mem_busy) begin
          if_stall = 1'b1;
          ds_stall = 1'b1;
          pend_d   = 1'b1;
          state_d  = HC_MEM_WAIT;
        end else begin
          ds_flush = 1'b1;
          state_d  = HC_FLUSH2;
        end
      end
      HC_FLUSH2: begin
        if (hc.hc_i_mem_busy) begin
          if_stall = 1'b1;
          ds_stall = 1'b1;
          pend_d   = 1'b1;
          state_d  = HC_MEM_WAIT;
        end else if (hc.hc_i_br_taken) begin
          ds_flush = 1'b1;
          ex_flush = 1'b1;
          state_d  = HC_FLUSH1;
        end else begin
          ds_flush = 1'b1;
          state_d  = HC_RUN;
        end
      end
      default: state_d = HC_RUN;
    endcase
    if (!hc_rst) begin
      if_stall = 1'b0;
      ds_stall = 1'b0;
      ds_flush = 1'b0;
      ex_flush = 1'b0;
    end
  end

  // State and pending-branch registers.
  always_ff @(posedge hc_clk) begin
    if (!hc_rst) begin
      state_q <= HC_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  hc_watchdog #(
    .CWIDTH  (CWIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk  (hc_clk),
    .rst  (hc_rst),
    .clr  ((state_q != HC_MEM_WAIT) && (state_d == HC_MEM_WAIT)),
    .en   (state_q == HC_MEM_WAIT),
    .flag (tmo)
  );

  assign hc.hc_o_if_stall = if_stall;
  assign hc.hc_o_ds_stall = ds_stall;
  assign hc.hc_o_ds_flush = ds_flush;
  assign hc.hc_o_ex_flush = ex_flush;
  assign hc.hc_o_state    = hc_rst ? state_q : HC_RUN;
  assign hc.hc_o_timeout  = hc_rst & tmo;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  // Profiling counters: fetch-stall cycles and redirects out of RUN.
  always_ff @(posedge hc_clk) begin
    if (!hc_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (if_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((state_q == HC_RUN) && (state_d == HC_FLUSH1)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign hc.hc_o_stall_cnt = stall_cnt;
  assign hc.hc_o_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus for hazard_ctrl with literal checks and a
// cycle-level reference model compared on every falling edge.
module tb_hazard_ctrl;

  localparam int unsigned TMO = 4;

  logic hc_clk;
  logic hc_rst;
  int   total;
  int   bad;

  hazard_ctrl_if #(.AWIDTH(5)) bus ();

  hazard_ctrl #(
    .AWIDTH  (5),
    .TIMEOUT (TMO),
    .CWIDTH  (8)
  ) dut (
    .hc_clk (hc_clk),
    .hc_rst (hc_rst),
    .hc     (bus)
  );

  initial hc_clk = 1'b0;
  always #5 hc_clk = ~hc_clk;

  // {state[1:0], if_stall, ds_stall, ds_flush, ex_flush, timeout}
  logic [6:0] got;
  assign got = {bus.hc_o_state, bus.hc_o_if_stall, bus.hc_o_ds_stall,
                bus.hc_o_ds_flush, bus.hc_o_ex_flush, bus.hc_o_timeout};

  // Reference model: pipeline situation tracked as counters and flags.
  bit   armed;
  int   flush_left;   // decode-flush cycles still owed after this one
  bit   waiting;
  bit   pend;
  int   wait_n;       // completed wait cycles since the wait began
  bit   tmo;
  logic [1:0] e_state;
  logic e_if, e_ds, e_dsf, e_exf, e_tmo, m_lu, m_trap;
  logic [6:0] exp_v;

  always @(negedge hc_clk) begin
    if (!hc_rst) armed = 1'b1;
    if (armed) begin
      e_if = 0; e_ds = 0; e_dsf = 0; e_exf = 0;
      m_trap = bus.hc_i_trap && bus.hc_i_ds_ce;
      m_lu = bus.hc_i_ds_ce && bus.hc_i_ex_ce && bus.hc_i_ex_load &&
             (bus.hc_i_ex_rd != 0) &&
             ((bus.hc_i_ds_use_rs1 && bus.hc_i_ds_rs1 == bus.hc_i_ex_rd) ||
              (bus.hc_i_ds_use_rs2 && bus.hc_i_ds_rs2 == bus.hc_i_ex_rd));
      if (!hc_rst) begin
        e_state = 2'd0; e_tmo = 1'b0;
        flush_left = 0; waiting = 0; pend = 0; wait_n = 0; tmo = 0;
      end else begin
        e_tmo = tmo;
        e_state = waiting ? 2'd1 : (flush_left == 2) ? 2'd2 :
                  (flush_left == 1) ? 2'd3 : 2'd0;
        if (waiting) begin
          e_if = 1; e_ds = 1;
          if (wait_n < 255) wait_n++;
          if (wait_n >= TMO) tmo = 1;
          if (bus.hc_i_br_taken) pend = 1;
          if (!bus.hc_i_mem_busy) begin
            waiting = 0;
            if (pend) flush_left = 2;
            pend = 0;
          end
        end else if (bus.hc_i_mem_busy) begin
          e_if = 1; e_ds = 1;
          pend = bus.hc_i_br_taken || (flush_left > 0);
          waiting = 1; wait_n = 0; flush_left = 0;
        end else if (flush_left == 2) begin
          e_dsf = 1; flush_left = 1;
        end else if (flush_left == 1) begin
          e_dsf = 1;
          if (bus.hc_i_br_taken) begin e_exf = 1; flush_left = 2; end
          else flush_left = 0;
        end else if (bus.hc_i_br_taken || m_trap) begin
          e_dsf = 1; e_exf = 1; flush_left = 2;
        end else if (m_lu) begin
          e_if = 1; e_ds = 1; e_exf = 1;
        end
      end
      exp_v = {e_state, e_if, e_ds, e_dsf, e_exf, e_tmo};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL model t=%0t got=%b want=%b", $time, got, exp_v);
      end
    end
  end

  task automatic step(input bit chk, input logic [6:0] want, input string name);
    @(negedge hc_clk);
    if (chk) begin
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s got=%b want=%b", name, got, want);
      end
    end
    @(posedge hc_clk);
    #1;
  endtask

  task automatic idle_in();
    bus.hc_i_ds_ce = 1; bus.hc_i_ds_rs1 = 5'd1; bus.hc_i_ds_rs2 = 5'd2;
    bus.hc_i_ds_use_rs1 = 1; bus.hc_i_ds_use_rs2 = 1;
    bus.hc_i_ex_ce = 1; bus.hc_i_ex_load = 0; bus.hc_i_ex_rd = 5'd5;
    bus.hc_i_br_taken = 0; bus.hc_i_trap = 0; bus.hc_i_mem_busy = 0;
  endtask

  task automatic do_reset();
    idle_in();
    hc_rst = 0;
    step(1, 7'b00_0000_0, "rst_hold");
    hc_rst = 1;
  endtask

  initial begin
    total = 0; bad = 0;
    idle_in();
    // Reset held two cycles with mem_busy and br_taken active.
    hc_rst = 0; bus.hc_i_mem_busy = 1; bus.hc_i_br_taken = 1;
    step(1, 7'b00_0000_0, "reset_c0");
    step(1, 7'b00_0000_0, "reset_c1");
    hc_rst = 1; idle_in();
    step(1, 7'b00_0000_0, "idle");

    // Load-use on rs2, then on rs1, then cases that must not stall.
    bus.hc_i_ex_load = 1; bus.hc_i_ex_rd = 5'd3; bus.hc_i_ds_rs2 = 5'd3;
    step(1, 7'b00_1101_0, "lu_rs2");
    bus.hc_i_ex_load = 0;
    step(1, 7'b00_0000_0, "lu_gone");
    bus.hc_i_ex_load = 1; bus.hc_i_ex_rd = 5'd0;
    bus.hc_i_ds_rs1 = 5'd0; bus.hc_i_ds_rs2 = 5'd0;
    step(1, 7'b00_0000_0, "lu_x0");
    bus.hc_i_ex_rd = 5'd7; bus.hc_i_ds_rs1 = 5'd7; bus.hc_i_ds_rs2 = 5'd2;
    step(1, 7'b00_1101_0, "lu_rs1");
    bus.hc_i_ds_use_rs1 = 0;
    step(1, 7'b00_0000_0, "lu_unused_rs1");
    bus.hc_i_ds_use_rs1 = 1; bus.hc_i_ex_ce = 0;
    step(1, 7'b00_0000_0, "lu_ex_invalid");
    idle_in();

    // Taken branch: three decode flushes, one execute flush.
    bus.hc_i_br_taken = 1;
    step(1, 7'b00_0011_0, "br_run");
    bus.hc_i_br_taken = 0;
    step(1, 7'b10_0010_0, "br_flush1");
    step(1, 7'b11_0010_0, "br_flush2");
    step(1, 7'b00_0000_0, "br_back_run");

    // Decode trap, then a trap that is not qualified by ds_ce.
    bus.hc_i_trap = 1;
    step(1, 7'b00_0011_0, "trap_run");
    bus.hc_i_trap = 0;
    step(1, 7'b10_0010_0, "trap_flush1");
    step(1, 7'b11_0010_0, "trap_flush2");
    bus.hc_i_trap = 1; bus.hc_i_ds_ce = 0;
    step(1, 7'b00_0000_0, "trap_unqualified");
    idle_in();

    // Branch in FLUSH2 restarts the sequence.
    bus.hc_i_br_taken = 1;
    step(1, 7'b00_0011_0, "rb_run");
    bus.hc_i_br_taken = 0;
    step(1, 7'b10_0010_0, "rb_flush1");
    bus.hc_i_br_taken = 1;
    step(1, 7'b11_0011_0, "rb_flush2_br");
    bus.hc_i_br_taken = 0;
    step(1, 7'b10_0010_0, "rb_flush1_again");
    step(1, 7'b11_0010_0, "rb_flush2_again");
    step(1, 7'b00_0000_0, "rb_run_again");

    // Memory busy pre-empts FLUSH1; flush replays after the wait.
    bus.hc_i_br_taken = 1;
    step(1, 7'b00_0011_0, "pre_run");
    bus.hc_i_br_taken = 0; bus.hc_i_mem_busy = 1;
    step(1, 7'b10_1100_0, "pre_flush1_busy");
    bus.hc_i_mem_busy = 0;
    step(1, 7'b01_1100_0, "pre_wait_exit");
    step(1, 7'b10_0010_0, "pre_replay1");
    step(1, 7'b11_0010_0, "pre_replay2");
    step(1, 7'b00_0000_0, "pre_run_end");

    // Memory wait of 4 busy cycles with branch in wait cycle 2.
    do_reset();
    bus.hc_i_mem_busy = 1;
    step(1, 7'b00_1100_0, "mw_run_busy");
    step(1, 7'b01_1100_0, "mw_wait1");
    bus.hc_i_br_taken = 1;
    step(1, 7'b01_1100_0, "mw_wait2_br");
    bus.hc_i_br_taken = 0;
    step(1, 7'b01_1100_0, "mw_wait3");
    bus.hc_i_mem_busy = 0;
    step(1, 7'b01_1100_0, "mw_exit");
    step(1, 7'b10_0010_1, "mw_flush1");
    step(1, 7'b11_0010_1, "mw_flush2");
    step(1, 7'b00_0000_1, "mw_run");

    // Watchdog: busy held 10 cycles; sticky until reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.hc_i_mem_busy = 1;
      if (i == 0)      step(1, 7'b00_1100_0, "wd_enter");
      else if (i <= 4) step(1, 7'b01_1100_0, "wd_wait_low");
      else             step(1, 7'b01_1100_1, "wd_wait_high");
    end
    bus.hc_i_mem_busy = 0;
    step(1, 7'b01_1100_1, "wd_exit");
    step(1, 7'b00_0000_1, "wd_sticky0");
    step(1, 7'b00_0000_1, "wd_sticky1");
    hc_rst = 0;
    step(1, 7'b00_0000_0, "wd_in_reset");
    hc_rst = 1;
    step(1, 7'b00_0000_0, "wd_cleared");

    // Priority: busy, branch and load-use together.
    bus.hc_i_mem_busy = 1; bus.hc_i_br_taken = 1;
    bus.hc_i_ex_load = 1; bus.hc_i_ex_rd = 5'd2;
    step(1, 7'b00_1100_0, "prio_run");
    idle_in();
    step(1, 7'b01_1100_0, "prio_wait_exit");
    step(1, 7'b10_0010_0, "prio_pend_flush1");
    step(1, 7'b11_0010_0, "prio_pend_flush2");
    step(1, 7'b00_0000_0, "prio_run_end");

    // Reset mid-flush and mid-wait abandons the sequence.
    bus.hc_i_br_taken = 1;
    step(1, 7'b00_0011_0, "rf_run");
    bus.hc_i_br_taken = 0; hc_rst = 0;
    step(1, 7'b00_0000_0, "rf_reset");
    hc_rst = 1;
    step(1, 7'b00_0000_0, "rf_no_replay");
    bus.hc_i_mem_busy = 1;
    step(1, 7'b00_1100_0, "rw_run_busy");
    bus.hc_i_br_taken = 1;
    step(1, 7'b01_1100_0, "rw_wait_br");
    bus.hc_i_br_taken = 0; hc_rst = 0;
    step(1, 7'b00_0000_0, "rw_reset");
    hc_rst = 1; bus.hc_i_mem_busy = 0;
    step(1, 7'b00_0000_0, "rw_no_replay");
    step(1, 7'b00_0000_0, "rw_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit reached t=%0t", $time);
    $fatal(1, "time limit");
  end

endmodule
